// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard inputs from the pipeline stages and the latch/PC controls going back to them.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [4:0]       ID_rs1, ID_rs2, EX_rd;
    logic             ID_use_rs1, ID_use_rs2, EX_is_load, EX_redirect;
    logic             imem_ready, dmem_req, dmem_ready, clr_cnt;
    logic             PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN;
    logic             Data_stall, flush, ID_EX_flush, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;
    modport master (
        output ID_rs1, ID_rs2, EX_rd, ID_use_rs1, ID_use_rs2, EX_is_load, EX_redirect,
        output imem_ready, dmem_req, dmem_ready, clr_cnt,
        input  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
        input  Data_stall, flush, ID_EX_flush, mem_timeout, stall_cnt, flush_cnt, freeze_cnt
    );
    modport slave (
        input  ID_rs1, ID_rs2, EX_rd, ID_use_rs1, ID_use_rs2, EX_is_load, EX_redirect,
        input  imem_ready, dmem_req, dmem_ready, clr_cnt,
        output PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
        output Data_stall, flush, ID_EX_flush, mem_timeout, stall_cnt, flush_cnt, freeze_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-cycle advance/hold/bubble decisions for the 5-stage pipe, freeze watchdog and hazard counters.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input logic                clk,
    input logic                rst,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] LAST = WW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
    typedef enum logic [1:0] {RUN, FREEZE, HALT} state_t;
    state_t           state;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] stall_q, flush_q, freeze_q;
    logic freeze, load_use, halt, sel_redir, sel_lu, run_en, wd_fire;
    always_comb begin
        freeze    = ~bus.imem_ready | (bus.dmem_req & ~bus.dmem_ready);
        load_use  = bus.EX_is_load & (bus.EX_rd != 5'd0) &
                    ((bus.ID_use_rs1 & (bus.ID_rs1 == bus.EX_rd)) |
                     (bus.ID_use_rs2 & (bus.ID_rs2 == bus.EX_rd)));
        halt      = state == HALT;
        run_en    = ~halt & ~freeze;
        sel_redir = run_en & bus.EX_redirect;
        sel_lu    = run_en & ~bus.EX_redirect & load_use;
        wd_fire   = (MAX_WAIT > 0) && freeze && (wait_cnt == LAST);
    end
    // A redirect outranks load-use: the instruction that would stall is wrong-path anyway.
    always_comb begin
        bus.PC_EN       = run_en & ~sel_lu;
        bus.IF_ID_EN    = run_en;
        bus.ID_EX_EN    = run_en;
        bus.EX_MEM_EN   = run_en;
        bus.MEM_WB_EN   = run_en;
        bus.Data_stall  = sel_lu;
        bus.flush       = sel_redir;
        bus.ID_EX_flush = sel_redir | sel_lu;
        bus.mem_timeout = halt;
        bus.stall_cnt   = stall_q;
        bus.flush_cnt   = flush_q;
        bus.freeze_cnt  = freeze_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= freeze ? wait_cnt + 1'b1 : '0;
            case (state)
                RUN:     state <= wd_fire ? HALT : (freeze ? FREEZE : RUN);
                FREEZE:  state <= wd_fire ? HALT : (freeze ? FREEZE : RUN);
                default: state <= HALT;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt) begin
            stall_q  <= '0;
            flush_q  <= '0;
            freeze_q <= '0;
        end else if (!halt) begin
            stall_q  <= stall_q + CNT_W'(sel_lu);
            flush_q  <= flush_q + CNT_W'(sel_redir);
            freeze_q <= freeze_q + CNT_W'(freeze);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboarded directed and random stimulus against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int MW = 4;
  localparam int CW = 8;
  typedef struct {
    bit       rst, load, redir, imem, dreq, drdy, clr, use1, use2;
    bit [4:0] rs1, rs2, rd;
  } stim_t;
  typedef struct packed {
    logic [4:0]    en;
    logic          stall, flush, idex_flush, timeout;
    logic [CW-1:0] sc, fc, zc;
  } obs_t;
  logic clk = 0, rst = 1;
  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();
  pipe_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  obs_t q[$];
  int vectors = 0, errors = 0;
  bit m_halt = 0;
  int m_consec = 0, m_stall = 0, m_flush = 0, m_freeze = 0;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      obs_t e, a;
      e = q.pop_front();
      a = '{en: {bus.PC_EN, bus.IF_ID_EN, bus.ID_EX_EN, bus.EX_MEM_EN, bus.MEM_WB_EN},
            stall: bus.Data_stall, flush: bus.flush, idex_flush: bus.ID_EX_flush,
            timeout: bus.mem_timeout, sc: bus.stall_cnt, fc: bus.flush_cnt, zc: bus.freeze_cnt};
      vectors++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl @%0t: actual en=%b st=%b fl=%b idf=%b to=%b cnt=%0d/%0d/%0d required en=%b st=%b fl=%b idf=%b to=%b cnt=%0d/%0d/%0d",
                 $time, a.en, a.stall, a.flush, a.idex_flush, a.timeout, a.sc, a.fc, a.zc,
                 e.en, e.stall, e.flush, e.idex_flush, e.timeout, e.sc, e.fc, e.zc);
      end
    end
  end
  task automatic chk(input bit ok, input string what);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s @%0t", what, $time);
    end
  endtask
  function automatic stim_t idle();
    stim_t s = '{default: 0};
    s.imem = 1;
    return s;
  endfunction
  task automatic step(input stim_t s);
    obs_t e;
    bit frz, lu, go;
    @(posedge clk); #1;
    rst = s.rst;
    bus.ID_rs1 = s.rs1; bus.ID_rs2 = s.rs2; bus.EX_rd = s.rd;
    bus.ID_use_rs1 = s.use1; bus.ID_use_rs2 = s.use2; bus.EX_is_load = s.load;
    bus.EX_redirect = s.redir; bus.imem_ready = s.imem; bus.dmem_req = s.dreq;
    bus.dmem_ready = s.drdy; bus.clr_cnt = s.clr;
    frz = !s.imem || (s.dreq && !s.drdy);
    lu  = s.load && s.rd != 0 && ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
    go  = !m_halt && !frz;
    e.en = go ? ((!s.redir && lu) ? 5'b01111 : 5'b11111) : 5'b00000;
    e.stall = go && !s.redir && lu;
    e.flush = go && s.redir;
    e.idex_flush = go && (s.redir || lu);
    e.timeout = m_halt;
    e.sc = CW'(m_stall); e.fc = CW'(m_flush); e.zc = CW'(m_freeze);
    q.push_back(e);
    if (s.rst || s.clr) begin
      m_stall = 0; m_flush = 0; m_freeze = 0;
    end else if (!m_halt) begin
      m_stall  += int'(e.stall);
      m_flush  += int'(e.flush);
      m_freeze += int'(frz);
    end
    if (s.rst) begin
      m_halt = 0; m_consec = 0;
    end else begin
      m_consec = frz ? m_consec + 1 : 0;
      if (MW > 0 && m_consec >= MW) m_halt = 1;
    end
  endtask
  initial begin
    stim_t s;
    bus.ID_rs1 = 0; bus.ID_rs2 = 0; bus.EX_rd = 0; bus.ID_use_rs1 = 0; bus.ID_use_rs2 = 0;
    bus.EX_is_load = 0; bus.EX_redirect = 0; bus.imem_ready = 1; bus.dmem_req = 0;
    bus.dmem_ready = 0; bus.clr_cnt = 0;
    s = idle(); s.rst = 1;
    step(s);
    step(idle());
    #1;
    chk({bus.PC_EN, bus.IF_ID_EN, bus.ID_EX_EN, bus.EX_MEM_EN, bus.MEM_WB_EN} === 5'b11111 &&
        bus.Data_stall === 1'b0 && bus.flush === 1'b0 && bus.ID_EX_flush === 1'b0 &&
        bus.mem_timeout === 1'b0 && bus.stall_cnt === '0 && bus.flush_cnt === '0 &&
        bus.freeze_cnt === '0, "reset state");
    s = idle(); s.load = 1; s.rd = 5; s.rs1 = 5; s.use1 = 1;
    step(s);
    step(idle());
    s.rd = 0; s.rs1 = 0;
    step(s);
    s = idle(); s.load = 1; s.rd = 7; s.rs2 = 7; s.use2 = 1; s.redir = 1;
    step(s);
    step(idle());
    s = idle(); s.dreq = 1;
    repeat (3) step(s);
    s.drdy = 1;
    step(s);
    step(idle());
    s = idle(); s.redir = 1; s.imem = 0;
    repeat (2) step(s);
    s.imem = 1;
    step(s);
    step(idle());
    s = idle(); s.imem = 0;
    repeat (4) step(s);
    step(idle());
    #1;
    chk(bus.mem_timeout === 1'b1 &&
        {bus.PC_EN, bus.IF_ID_EN, bus.ID_EX_EN, bus.EX_MEM_EN, bus.MEM_WB_EN} === 5'b00000,
        "expired wait halt");
    repeat (2) step(idle());
    s = idle(); s.load = 1; s.rd = 3; s.rs1 = 3; s.use1 = 1;
    step(s);
    s = idle(); s.rst = 1;
    step(s);
    step(idle());
    s = idle(); s.load = 1; s.rd = 9; s.rs1 = 9; s.use1 = 1; s.clr = 1;
    step(s);
    step(idle());
    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom % 120) == 0;
      s.clr   = ($urandom % 60) == 0;
      s.load  = ($urandom % 2) == 0;
      s.redir = ($urandom % 6) == 0;
      s.imem  = ($urandom % 8) != 0;
      s.dreq  = ($urandom % 3) == 0;
      s.drdy  = ($urandom % 2) == 0;
      s.use1  = $urandom % 2;
      s.use2  = $urandom % 2;
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.rd    = 5'($urandom_range(0, 3));
      step(s);
    end
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard controller for the 5-stage RV32 pipeline. Each cycle it decides whether every stage advances, holds, or takes a bubble, and drives the enable/stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC register. It detects load-use hazards, branch/jump redirects resolved in EX, and memory wait states, and runs a freeze watchdog. It also keeps hazard statistics counters.

## Interface
- MAX_WAIT, 16, consecutive freeze cycles allowed before HALT; 0 disables the watchdog
- CNT_W, 32, width of each statistics counter
- clk  in  1  pipeline clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID
- ID_use_rs1, ID_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- EX_rd  in  5  destination register of the instruction in EX
- EX_is_load  in  1  EX instruction is a load
- EX_redirect  in  1  taken branch/jump resolved in EX this cycle
- imem_ready  in  1  instruction memory returns valid data this cycle
- dmem_req, dmem_ready  in  1 each  MEM stage access active / completes this cycle
- clr_cnt  in  1  synchronous clear of statistics counters
- PC_EN  out  1  PC register update enable
- IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN  out  1 each  latch enables
- Data_stall  out  1  IF/ID hold for a data hazard
- flush  out  1  IF/ID loads NOP 0x00000013
- ID_EX_flush  out  1  ID/EX loads a bubble (NOP, no writes)
- mem_timeout  out  1  sticky watchdog error, equals state==HALT
- stall_cnt, flush_cnt, freeze_cnt  out  CNT_W each  event counters

## Operation
- Combinational terms:
  - freeze = ~imem_ready | (dmem_req & ~dmem_ready).
  - load_use = EX_is_load & (EX_rd != 0) & ((ID_use_rs1 & ID_rs1 == EX_rd) | (ID_use_rs2 & ID_rs2 == EX_rd)).
- Control outputs are combinational from the state and the current inputs. Priority, highest first:
  - HALT: all EN = 0, Data_stall = flush = ID_EX_flush = 0.
  - freeze: all EN = 0, Data_stall = flush = ID_EX_flush = 0. The whole pipe holds.
  - EX_redirect: all EN = 1, flush = 1, ID_EX_flush = 1, Data_stall = 0. PC loads the target.
  - load_use: PC_EN = 0, Data_stall = 1, ID_EX_flush = 1, other EN = 1.
  - Otherwise: all EN = 1, Data_stall = flush = ID_EX_flush = 0.
- A redirect coinciding with load_use is handled as a redirect: the stalled instruction is wrong-path.
- A redirect during freeze takes effect in the first unfrozen cycle. EX is held, so EX_redirect is still asserted then.
- FSM states:
  - RUN: freeze -> FREEZE, else stay.
  - FREEZE: ~freeze -> RUN. If the watchdog fires -> HALT.
  - HALT: exits only on rst.
- Watchdog:
  - wait_cnt (width ceil(log2(MAX_WAIT+1))) is cleared in any cycle where freeze = 0 and increments in each freeze cycle.
  - When freeze is high and wait_cnt == MAX_WAIT-1, the next state is HALT. HALT is therefore entered at the edge that ends the MAX_WAIT-th consecutive freeze cycle.
  - With MAX_WAIT = 0 the FSM never enters HALT.
- Counters are not updated in HALT. They wrap modulo 2^CNT_W. Per cycle:
  - stall_cnt +1 in each cycle where the load_use branch is selected.
  - flush_cnt +1 in each cycle where the redirect branch is selected.
  - freeze_cnt +1 in each freeze cycle.
- clr_cnt zeroes all three counters at the edge. It has priority over increments and does not affect the FSM.

## Timing
- Reset values: state = RUN, wait_cnt = 0, all counters = 0, mem_timeout = 0. With reset-default inputs (imem_ready = 1, no hazards), all EN = 1 and stall/flush outputs = 0.
- rst asserted mid-freeze or in HALT returns the block to RUN at the next edge, with counters cleared.
- Zero-latency control: enables, stalls and flushes respond in the same cycle as their inputs.
- Counters and mem_timeout reflect events one edge later.
- A load-use hazard lasts exactly 1 cycle. After the bubble the load is in MEM and forwarding covers the dependency.

## Test plan
- Load-use: EX_is_load = 1, EX_rd = 5, ID_rs1 = 5, ID_use_rs1 = 1 for one cycle -> PC_EN = 0, Data_stall = 1, ID_EX_flush = 1 that cycle; stall_cnt = 1 next cycle. Repeat with EX_rd = 0 -> no stall.
- Redirect + load_use in the same cycle -> flush = 1, ID_EX_flush = 1, Data_stall = 0, PC_EN = 1; flush_cnt +1, stall_cnt unchanged.
- dmem_req = 1, dmem_ready = 0 for 3 cycles, then ready -> all EN = 0 for 3 cycles, freeze_cnt = 3, state back to RUN, no mem_timeout.
- EX_redirect held through a 2-cycle imem freeze -> flush = 0 while frozen, flush = 1 in the first ready cycle, flush_cnt = 1.
- MAX_WAIT = 4, imem_ready = 0 for 4 cycles -> mem_timeout = 1 after the 4th edge, all EN = 0 even after imem_ready returns, until rst clears it.
- clr_cnt in the same cycle as a load_use -> stall_cnt = 0 afterwards; rst mid-HALT -> RUN, all counters = 0.
